dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-port arbiter that shares the single-port data memory between the CPU core port (load/store/push/pop traffic) and an I/O port (keypad scanner / display refresh engine).
- Sits between the requesters and the data memory and drives its address, write data and write-enable.
- Uses round-robin arbitration with an optional bounded I/O burst lock.
- Each transaction is a fixed 3-cycle IDLE -> ACCESS -> ACK sequence with a one-cycle ack pulse.

Parameters:
- AW, 16: address width of both ports and of the memory.
- DW, 16: data width.
- MAX_BURST, 4: maximum number of consecutive I/O grants while io_lock is held (must be >= 1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_req  in  1  CPU request; held high with cpu_we/addr/wdata stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DW  read data, registered, valid from the cpu_ack cycle and held until the next CPU read.
- io_req  in  1  I/O request; same rules as cpu_req.
- io_we  in  1  I/O write enable.
- io_addr  in  AW  I/O address.
- io_wdata  in  DW  I/O write data.
- io_lock  in  1  requests back-to-back I/O grants (burst).
- io_ack  out  1  one-cycle completion pulse.
- io_rdata  out  DW  registered I/O read data; same rules as cpu_rdata.
- mem_addr  out  AW  memory address.
- mem_din  out  DW  memory write data.
- mem_we  out  1  memory write enable (1 = write, 0 = read).
- mem_dout  in  DW  memory read data (combinational read of mem_addr).
- owner  out  2  00 = none, 01 = CPU, 10 = I/O; reflects the current ACCESS/ACK owner.

Behaviour:
Reset:
- Clock is clk. Reset is rst: synchronous, active-high.
- On reset: state = IDLE, owner = 00, last_owner = IO (so CPU wins the first tie), burst_cnt = 0.
- On reset: cpu_ack = io_ack = 0, cpu_rdata = io_rdata = 0, mem_addr = 0, mem_din = 0, mem_we = 0.

FSM:
- IDLE: evaluate requests each cycle.
  - No request -> stay in IDLE.
  - Exactly one request -> grant that requester, go to ACCESS.
- IDLE, both requesting: lock check comes first.
  - If last_owner = IO, io_lock = 1 and burst_cnt < MAX_BURST -> grant IO.
  - Otherwise grant the requester that is not last_owner.
- ACCESS (1 cycle), bus drive:
  - mem_addr and mem_din come from the owner.
  - mem_we = owner_we AND NOT rst.
- ACCESS, end-of-cycle effects:
  - The memory write commits at the closing edge.
  - On a read, mem_dout is captured into the owner's rdata register at the same edge.
  - The non-owner rdata register is unchanged.
  - Next state is ACK.
- ACK (1 cycle):
  - The owner's ack = 1; mem_we = 0; mem_addr and mem_din hold their values.
  - No arbitration happens in ACK.
  - Next state is IDLE; owner is cleared to 00 on entry to IDLE.
- IDLE outputs: mem_we = 0; mem_addr and mem_din driven to 0.

Latency and throughput:
- A request sampled high in IDLE at edge k gives ACCESS in cycle k+1 and ack in cycle k+2.
- Maximum throughput is one transaction per 3 cycles.

Requester rule:
- In the cycle after ack, a requester must either drop req or present a new request. Either way it is re-sampled in IDLE.

Burst counter (updated on each grant):
- IO grant: burst_cnt <= (last_owner = IO AND io_lock) ? min(burst_cnt + 1, MAX_BURST) : 1.
- CPU grant: burst_cnt <= 0.
- last_owner <= the granted port.

Lock boundaries:
- io_lock is ignored when cpu_req = 0. A lone I/O request is always granted, but the counter still saturates.
- io_lock dropped mid-burst -> the next tie follows normal round-robin.

Other boundaries:
- Requests that change during ACCESS/ACK do not affect the transaction in flight; addr/we/wdata are sampled combinationally in ACCESS only.
- rst asserted in ACCESS: no write commits, and state = IDLE, ack = 0, rdata = 0 next cycle.
- rst asserted in ACK: the ack in that cycle is still visible; all state is reset next cycle.
- Address wrap: none. Addresses are passed through unchanged.

Test Plan:
1. Reset, then CPU write (addr 0x0010, data 0x1234) followed by a CPU read of 0x0010 -> mem_we = 1 only in the first ACCESS cycle; cpu_ack at cycles 2 and 5 after the first req; cpu_rdata = 0x1234 in the second ack cycle.
2. cpu_req and io_req both rise in the same cycle after reset, both reading, held continuously -> grant order CPU, IO, CPU, IO; acks 3 cycles apart, alternating; owner goes 01/10 accordingly.
3. io_lock = 1 with both requesting continuously, MAX_BURST = 4, starting from a CPU grant -> order CPU, IO, IO, IO, IO, CPU, IO...
4. Only io_req, with io_lock = 0, for 3 transactions -> 3 io_acks spaced 3 cycles apart; cpu_ack never asserted; cpu_rdata unchanged.
5. Assert rst during the ACCESS cycle of an I/O write to 0x0020 -> mem_we = 0 in that cycle; a later read of 0x0020 returns the prior contents; no io_ack; io_rdata = 0.
6. IO write of 0x00FF while cpu_addr/cpu_wdata toggle every cycle -> mem_addr/mem_din follow the IO port only during ACCESS/ACK and are 0 in IDLE.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data-memory port between the CPU and I/O engines.
// Round-robin with bounded I/O burst lock; IDLE -> ACCESS -> ACK per txn.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cpu_req/we/addr/wdata CPU request side
//   cpu_ack, cpu_rdata   CPU one-cycle ack, registered read data
//   io_req/we/addr/wdata I/O request side
//   io_lock              I/O asks for back-to-back grants
//   io_ack, io_rdata     I/O one-cycle ack, registered read data
//   mem_addr/din/we      memory drive
//   mem_dout             memory combinational read data
//   owner                00 none, 01 CPU, 10 I/O

module dm_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,

  input  logic          io_req,
  input  logic          io_we,
  input  logic [AW-1:0] io_addr,
  input  logic [DW-1:0] io_wdata,
  input  logic          io_lock,
  output logic          io_ack,
  output logic [DW-1:0] io_rdata,

  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout,

  output logic [1:0]    owner
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] C_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_IO   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_owner;
  logic [1:0]    w_owner_nxt;
  logic          r_last_io;
  logic          w_last_io_nxt;
  logic [CW-1:0] r_burst;
  logic [CW-1:0] w_burst_nxt;
  logic [CW-1:0] w_burst_inc;

  logic [AW-1:0] r_addr_hold;
  logic [DW-1:0] r_din_hold;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_io_rdata;

  logic          w_lock_hit;
  logic          w_grant_io;
  logic          w_grant_cpu;
  logic          w_own_io;
  logic          w_own_we;
  logic [AW-1:0] w_own_addr;
  logic [DW-1:0] w_own_wdata;

  // Lock only wins a tie while the I/O side already holds the
  // last grant and has burst budget left.
  assign w_lock_hit = r_last_io & io_lock
                    & (r_burst < C_MAX);

  // Lone I/O always wins; in a tie, I/O wins on lock or when the
  // CPU had the last grant.
  assign w_grant_io  = io_req
                     & (~cpu_req | w_lock_hit | ~r_last_io);
  assign w_grant_cpu = cpu_req & ~w_grant_io;

  assign w_burst_inc = (r_burst == C_MAX) ? r_burst
                                          : r_burst + C_ONE;

  assign w_own_io    = (r_owner == OWN_IO);
  assign w_own_we    = w_own_io ? io_we    : cpu_we;
  assign w_own_addr  = w_own_io ? io_addr  : cpu_addr;
  assign w_own_wdata = w_own_io ? io_wdata : cpu_wdata;

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_last_io_nxt = r_last_io;
    w_burst_nxt   = r_burst;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_io) begin
          w_state_nxt   = S_ACCESS;
          w_owner_nxt   = OWN_IO;
          w_last_io_nxt = 1'b1;
          w_burst_nxt   = (r_last_io & io_lock)
                        ? w_burst_inc : C_ONE;
        end else if (w_grant_cpu) begin
          w_state_nxt   = S_ACCESS;
          w_owner_nxt   = OWN_CPU;
          w_last_io_nxt = 1'b0;
          w_burst_nxt   = '0;
        end
      end
      S_ACCESS: begin
        w_state_nxt = S_ACK;
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
        w_owner_nxt = OWN_NONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_owner_nxt = OWN_NONE;
      end
    endcase
  end

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    unique case (r_state)
      S_ACCESS: begin
        mem_addr = w_own_addr;
        mem_din  = w_own_wdata;
        // Gate with rst so a reset in ACCESS never commits.
        mem_we   = w_own_we & ~rst;
      end
      S_ACK: begin
        mem_addr = r_addr_hold;
        mem_din  = r_din_hold;
      end
      default: begin
        mem_addr = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_NONE;
      r_last_io   <= 1'b1;
      r_burst     <= '0;
      r_addr_hold <= '0;
      r_din_hold  <= '0;
      r_cpu_rdata <= '0;
      r_io_rdata  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_last_io <= w_last_io_nxt;
      r_burst   <= w_burst_nxt;
      if (r_state == S_ACCESS) begin
        r_addr_hold <= w_own_addr;
        r_din_hold  <= w_own_wdata;
        if (!w_own_we) begin
          if (w_own_io) r_io_rdata  <= mem_dout;
          else          r_cpu_rdata <= mem_dout;
        end
      end
    end
  end

  assign cpu_ack   = (r_state == S_ACK) & (r_owner == OWN_CPU);
  assign io_ack    = (r_state == S_ACK) & (r_owner == OWN_IO);
  assign cpu_rdata = r_cpu_rdata;
  assign io_rdata  = r_io_rdata;
  assign owner     = r_owner;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: self-checking bench for dm_arbiter.
// Arbitration vector table plus hand-written timing sequences.

module tb_dm_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          io_req = 1'b0;
  logic          io_we = 1'b0;
  logic [AW-1:0] io_addr = '0;
  logic [DW-1:0] io_wdata = '0;
  logic          io_lock = 1'b0;
  logic          io_ack;
  logic [DW-1:0] io_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;
  logic [1:0]    owner;

  dm_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we),
    .io_addr(io_addr), .io_wdata(io_wdata),
    .io_lock(io_lock),
    .io_ack(io_ack), .io_rdata(io_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout),
    .owner(owner)
  );

  always #5 clk = ~clk;

  // Memory: unwritten words read as {a[7:0], ~a[7:0]}.
  logic [DW-1:0] mem [65536];
  bit            wr  [65536];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
      wr[mem_addr]  <= 1'b1;
    end
  end

  assign mem_dout = wr[mem_addr] ? mem[mem_addr]
                  : {mem_addr[7:0], ~mem_addr[7:0]};

  typedef struct {
    logic          is_io;
    logic          chk_rd;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct {
    string       name;
    int          n;
    logic [15:0] creq;
    logic [15:0] ireq;
    logic [15:0] lock;
    logic [15:0] exp_io;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cpu_ack || io_ack) begin
      check("single_ack", 32'(cpu_ack & io_ack), 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_ack: got cpu=%0d io=%0d expected none",
                 cpu_ack, io_ack);
      end else begin
        mon_e = sb.pop_front();
        check("ack_port", 32'(io_ack), 32'(mon_e.is_io));
        check("ack_owner", 32'(owner),
              mon_e.is_io ? 32'd2 : 32'd1);
        if (mon_e.chk_rd)
          check("ack_rdata",
                32'(mon_e.is_io ? io_rdata : cpu_rdata),
                32'(mon_e.rdata));
      end
    end
  end

  task automatic wait_ack(input string nm);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      got = cpu_ack | io_ack;
    end
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_timeout: got no ack expected ack within 12 cycles", nm);
      sb.delete();
    end
  endtask

  task automatic push(input logic io, input logic rd,
                      input logic [DW-1:0] d);
    exp_t e;
    e.is_io  = io;
    e.chk_rd = rd;
    e.rdata  = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_req = 1'b0;
    io_req = 1'b0;
    io_lock = 1'b0;
    cpu_we = 1'b0;
    io_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    do_reset();
    cpu_addr = 16'h0030;
    io_addr  = 16'h0040;
    for (int i = 0; i < v.n; i++) begin
      cpu_req = v.creq[i];
      io_req  = v.ireq[i];
      io_lock = v.lock[i];
      push(v.exp_io[i], 1'b1,
           v.exp_io[i] ? 16'h40BF : 16'h30CF);
      wait_ack(v.name);
    end
    cpu_req = 1'b0;
    io_req  = 1'b0;
    io_lock = 1'b0;
    if (v.creq == 16'h0)
      check({v.name, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
  endtask

  vec_t vt [6];

  logic       t1_we  [6] = '{0, 1, 0, 0, 0, 0};
  logic       t1_ack [6] = '{0, 0, 1, 0, 0, 1};
  logic [1:0] t1_own [6] = '{0, 1, 1, 0, 1, 1};
  logic [15:0] t1_ad [6] = '{16'h0, 16'h10, 16'h10,
                             16'h0, 16'h10, 16'h10};
  logic [15:0] t1_dn [6] = '{16'h0, 16'h1234, 16'h1234,
                             16'h0, 16'h0, 16'h0};
  logic [15:0] t6_ad [5] = '{16'h0, 16'h50, 16'h50, 16'h0, 16'h0};
  logic [15:0] t6_dn [5] = '{16'h0, 16'hFF, 16'hFF, 16'h0, 16'h0};
  logic        t6_we [5] = '{0, 1, 0, 0, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200us");
    $fatal(1);
  end

  initial begin
    vt[0] = '{"cpu_only",    3, 16'h0007, 16'h0000, 16'h0000, 16'h0000};
    vt[1] = '{"io_only",     3, 16'h0000, 16'h0007, 16'h0000, 16'h0007};
    vt[2] = '{"rr_tie",      4, 16'h000F, 16'h000F, 16'h0000, 16'h000A};
    vt[3] = '{"burst",       7, 16'h007F, 16'h007F, 16'h007E, 16'h005E};
    vt[4] = '{"lock_drop",   5, 16'h001F, 16'h001F, 16'h0003, 16'h000B};
    vt[5] = '{"lone_io_sat", 6, 16'h0020, 16'h003F, 16'h003F, 16'h001F};

    for (int v = 0; v < 6; v++) run_vec(vt[v]);

    // CPU write then read, cycle by cycle.
    do_reset();
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_io_ack", 32'(io_ack), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_io_rdata", 32'(io_rdata), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    cpu_addr  = 16'h0010;
    cpu_wdata = 16'h1234;
    cpu_we    = 1'b1;
    cpu_req   = 1'b1;
    push(1'b0, 1'b0, 16'h0);
    push(1'b0, 1'b1, 16'h1234);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("t1_we_c%0d", c), 32'(mem_we), 32'(t1_we[c]));
      check($sformatf("t1_ack_c%0d", c), 32'(cpu_ack), 32'(t1_ack[c]));
      check($sformatf("t1_own_c%0d", c), 32'(owner), 32'(t1_own[c]));
      check($sformatf("t1_addr_c%0d", c), 32'(mem_addr), 32'(t1_ad[c]));
      check($sformatf("t1_din_c%0d", c), 32'(mem_din), 32'(t1_dn[c]));
      if (c == 2) begin
        cpu_we    = 1'b0;
        cpu_wdata = 16'h0;
      end
      if (c == 5) cpu_req = 1'b0;
    end
    check("t1_cpu_rdata", 32'(cpu_rdata), 32'h1234);

    // Reset during the ACCESS cycle of an I/O write.
    do_reset();
    io_addr = 16'h0040;
    io_req  = 1'b1;
    push(1'b1, 1'b1, 16'h40BF);
    wait_ack("t5_pre");
    io_req = 1'b0;
    @(posedge clk); #1;
    io_we    = 1'b1;
    io_addr  = 16'h0020;
    io_wdata = 16'h5555;
    io_req   = 1'b1;
    @(posedge clk); #1;
    check("t5_owner_access", 32'(owner), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("t5_we_in_rst", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    io_req = 1'b0;
    io_we  = 1'b0;
    check("t5_io_ack", 32'(io_ack), 32'd0);
    check("t5_io_rdata", 32'(io_rdata), 32'd0);
    check("t5_owner", 32'(owner), 32'd0);
    io_req = 1'b1;
    push(1'b1, 1'b1, 16'h20DF);
    wait_ack("t5_read");
    io_req = 1'b0;

    // I/O write while CPU address/data toggle.
    @(posedge clk); #1;
    cpu_addr  = 16'($urandom);
    cpu_wdata = 16'($urandom);
    io_we     = 1'b1;
    io_addr   = 16'h0050;
    io_wdata  = 16'h00FF;
    io_req    = 1'b1;
    push(1'b1, 1'b0, 16'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("t6_addr_c%0d", c), 32'(mem_addr), 32'(t6_ad[c]));
      check($sformatf("t6_din_c%0d", c), 32'(mem_din), 32'(t6_dn[c]));
      check($sformatf("t6_we_c%0d", c), 32'(mem_we), 32'(t6_we[c]));
      if (c == 2) io_req = 1'b0;
      @(posedge clk); #1;
      cpu_addr  = 16'($urandom);
      cpu_wdata = 16'($urandom);
    end
    io_we    = 1'b0;
    cpu_we   = 1'b0;
    cpu_addr = 16'h0050;
    cpu_req  = 1'b1;
    push(1'b0, 1'b1, 16'h00FF);
    wait_ack("t6_read");
    cpu_req = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
